// File: rtl/ql_pkg.sv
// Shared Q-learning maze definitions: action encodings, default widths and
// the action-selector FSM state type.
package ql_pkg;

  localparam int N_ACTIONS       = 4;
  localparam int Q_WIDTH_DEF     = 16;
  localparam int STATE_WIDTH_DEF = 6;
  localparam int GOAL_STATE      = 25;

  localparam logic [3:0] ACT_UP    = 4'b0001;
  localparam logic [3:0] ACT_DOWN  = 4'b0010;
  localparam logic [3:0] ACT_LEFT  = 4'b0100;
  localparam logic [3:0] ACT_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DECIDE
  } sel_state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return ACT_UP << idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); advances only while enabled.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/epsilon_greedy_action_selector.sv
// Epsilon-greedy policy: reads the four Q(s,a) entries for the current state,
// tracks the signed argmax and optionally replaces it with a random action.
module epsilon_greedy_action_selector
  import ql_pkg::*;
#(
  parameter int          Q_WIDTH     = Q_WIDTH_DEF,
  parameter int          STATE_WIDTH = STATE_WIDTH_DEF,
  parameter int          EPS_WIDTH   = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [STATE_WIDTH-1:0]    current_state,
  input  logic [EPS_WIDTH-1:0]      epsilon,
  output logic                      q_rd_en,
  output logic [STATE_WIDTH+1:0]    q_rd_addr,
  input  logic signed [Q_WIDTH-1:0] q_rd_data,
  output logic [3:0]                next_action,
  output logic signed [Q_WIDTH-1:0] max_q,
  output logic                      explored,
  output logic                      action_valid,
  output logic                      busy
);

  localparam int AW = STATE_WIDTH + 2;

  sel_state_e               state_q;
  logic [15:0]              lfsr;
  logic                     q_rd_en_q;
  logic [AW-1:0]            q_rd_addr_q;
  logic                     cap_vld_q;
  logic [1:0]               cap_idx_q;
  logic [3:0]               next_action_q;
  logic signed [Q_WIDTH-1:0] max_q_q;
  logic                     explored_q;
  logic                     action_valid_q;
  logic                     busy_q;

  logic [EPS_WIDTH-1:0]     eps_q;
  logic [EPS_WIDTH-1:0]     rnd_byte_q;
  logic [1:0]               rnd_idx_q;
  logic signed [Q_WIDTH-1:0] best_q;
  logic [1:0]               best_idx_q;

  logic                     accept_d;
  logic                     explore_d;
  logic                     take_d;
  logic [1:0]               act_idx_d;
  logic                     unused_lfsr;

  assign unused_lfsr = ^lfsr[15:10];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .q   (lfsr)
  );

  // busy_q stays high through the action_valid cycle, so a start that lands on
  // the decide edge or the cycle after it is ignored rather than queued.
  always_comb begin
    accept_d  = en && start && (state_q == ST_IDLE) && !busy_q;
    explore_d = rnd_byte_q < eps_q;
    act_idx_d = explore_d ? rnd_idx_q : best_idx_q;
    take_d    = cap_vld_q && ((cap_idx_q == 2'd0) || (q_rd_data > best_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      q_rd_en_q      <= 1'b0;
      q_rd_addr_q    <= '0;
      cap_vld_q      <= 1'b0;
      cap_idx_q      <= 2'd0;
      next_action_q  <= ACT_UP;
      max_q_q        <= '0;
      explored_q     <= 1'b0;
      action_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else if (en) begin
      action_valid_q <= 1'b0;
      // Read data returns one cycle after the strobe: delay the index to match.
      cap_vld_q      <= q_rd_en_q;
      cap_idx_q      <= q_rd_addr_q[1:0];
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            state_q     <= ST_READ;
            q_rd_en_q   <= 1'b1;
            q_rd_addr_q <= {current_state, 2'b00};
            busy_q      <= 1'b1;
          end else begin
            busy_q      <= 1'b0;
          end
        end
        ST_READ: begin
          if (q_rd_addr_q[1:0] == 2'd3) begin
            q_rd_en_q <= 1'b0;
            state_q   <= ST_DRAIN;
          end else begin
            q_rd_addr_q <= {q_rd_addr_q[AW-1:2], q_rd_addr_q[1:0] + 2'd1};
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          next_action_q  <= onehot4(act_idx_d);
          max_q_q        <= best_q;
          explored_q     <= explore_d;
          action_valid_q <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (accept_d) begin
        eps_q      <= epsilon;
        rnd_byte_q <= lfsr[EPS_WIDTH-1:0];
        rnd_idx_q  <= lfsr[9:8];
      end
      if (take_d) begin
        best_q     <= q_rd_data;
        best_idx_q <= cap_idx_q;
      end
    end
  end

  assign q_rd_en      = q_rd_en_q;
  assign q_rd_addr    = q_rd_addr_q;
  assign next_action  = next_action_q;
  assign max_q        = max_q_q;
  assign explored     = explored_q;
  assign action_valid = action_valid_q & en;
  assign busy         = busy_q;

endmodule

// File: tb/tb_epsilon_greedy_action_selector.sv
// Scoreboard bench for the epsilon-greedy selector: directed decisions with
// hand-computed results plus exploration-rate batches.
module tb_epsilon_greedy_action_selector;

  logic              clk = 1'b0;
  logic              rst, en, start;
  logic [5:0]        cur;
  logic [7:0]        eps;
  logic              q_rd_en;
  logic [7:0]        q_rd_addr;
  logic signed [15:0] q_rd_data = '0;
  logic [3:0]        next_action;
  logic signed [15:0] max_q;
  logic              explored, action_valid, busy;

  always #5 clk = ~clk;

  epsilon_greedy_action_selector dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .current_state(cur), .epsilon(eps),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .next_action(next_action), .max_q(max_q), .explored(explored),
    .action_valid(action_valid), .busy(busy)
  );

  logic signed [15:0] qmem [256];
  logic [15:0] m_lfsr;

  // Q-table with one-cycle read latency; holds its output while en is low.
  always @(posedge clk) if (en && q_rd_en) q_rd_data <= qmem[q_rd_addr];

  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else if (en) m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);

  typedef struct packed {
    logic [3:0]         act;
    logic signed [15:0] mq;
    logic               expl;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int errors = 0, checks = 0, av_count = 0;
  bit stat_on = 0;
  int st_n, st_ex;
  int st_idx[4];
  logic [7:0] a_log[8];
  logic       r_log[8];
  logic       busy0, busy_av, busy_after;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic greedy(input logic [5:0] s, output logic [1:0] idx, output logic signed [15:0] mx);
    logic [1:0] kk;
    mx = qmem[{s, 2'd0}];
    idx = 2'd0;
    for (int k = 1; k < 4; k++) begin
      kk = k[1:0];
      if (qmem[{s, kk}] > mx) begin
        mx = qmem[{s, kk}];
        idx = kk;
      end
    end
  endtask

  task automatic issue(input logic [5:0] s, input logic [7:0] e, input exp_t x,
                       input bit use_model, input int want_idx);
    int tries = 0;
    exp_t y;
    logic [1:0] gi, ai;
    logic signed [15:0] gm;
    logic ex;
    logic [3:0] one;
    @(negedge clk);
    while (want_idx >= 0 && (int'(m_lfsr[9:8]) != want_idx || m_lfsr[7:0] == 8'hFF) && tries < 2000) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 2000) begin
      checks++; errors++;
      $display("FAIL rnd_wait: got no lfsr match in %0d cycles expected match", tries);
    end
    y = x;
    if (use_model) begin
      greedy(s, gi, gm);
      ex = m_lfsr[7:0] < e;
      ai = ex ? m_lfsr[9:8] : gi;
      one = 4'b0001;
      y.act = one << ai;
      y.mq = gm;
      y.expl = ex;
    end
    cur = s; eps = e; start = 1'b1;
    sb.push_back(y);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic watch(output int lat);
    int n = 0;
    lat = -1;
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      if (n < 8) begin a_log[n] = q_rd_addr; r_log[n] = q_rd_en; end
      if (n == 0) busy0 = busy;
      if (action_valid) begin lat = n; busy_av = busy; end
      else n++;
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic check_reads(input int base);
    for (int k = 0; k < 4; k++) begin
      chk("rd_en", r_log[k], 1);
      chk("rd_addr", a_log[k], base + k);
    end
    chk("rd_en_off", r_log[4], 0);
  endtask

  // Monitor: every action_valid pops the oldest pending decision.
  initial begin
    forever begin
      @(negedge clk);
      if (action_valid) begin
        av_count++;
        chk("no_x", int'($isunknown({next_action, max_q, explored, busy})), 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_valid: got action_valid=1 expected no pending decision");
        end else begin
          em = sb.pop_front();
          chk("next_action", next_action, em.act);
          chk("max_q", max_q, em.mq);
          chk("explored", explored, em.expl);
        end
        if (stat_on) begin
          st_n++;
          if (explored) begin
            st_ex++;
            case (next_action)
              4'b0001: st_idx[0]++;
              4'b0010: st_idx[1]++;
              4'b0100: st_idx[2]++;
              4'b1000: st_idx[3]++;
              default: st_idx[0] += 0;
            endcase
          end
        end
      end
    end
  end

  initial begin
    int lat, av0, t;
    rst = 1'b1; en = 1'b1; start = 1'b0; cur = '0; eps = '0;
    for (int i = 0; i < 256; i++) begin
      t = int'($urandom_range(0, 2000)) - 1000;
      qmem[i] = 16'(t);
    end
    qmem[28] = -16'sd5;   qmem[29] = 16'sd12;   qmem[30] = 16'sd3;    qmem[31] = 16'sd12;
    for (int i = 12; i < 16; i++) qmem[i] = -16'sd100;
    qmem[80] = -16'sd3;   qmem[81] = -16'sd1;   qmem[82] = -16'sd1;   qmem[83] = -16'sd9;
    qmem[40] = 16'sd1;    qmem[41] = 16'sd2;    qmem[42] = -16'sd7;   qmem[43] = 16'sd30;
    qmem[252] = 16'sd0;   qmem[253] = 16'sd0;   qmem[254] = 16'sd0;   qmem[255] = 16'sd5;

    #12;
    chk("rst_next_action", next_action, 1);
    chk("rst_max_q", max_q, 0);
    chk("rst_explored", explored, 0);
    chk("rst_action_valid", action_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", q_rd_en, 0);
    chk("rst_rd_addr", q_rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("lfsr_first", int'(dut.u_lfsr.q), 32'hACE1);

    // Greedy, state 7: tie between idx1 and idx3 resolves to down.
    issue(6'd7, 8'd0, '{4'b0010, 16'sd12, 1'b0}, 0, -1);
    watch(lat);
    check_reads(28);
    chk("greedy_lat", lat, 6);
    chk("busy_start", busy0, 1);
    chk("busy_at_valid", busy_av, 1);
    chk("busy_falls", busy_after, 0);

    issue(6'd3, 8'd0, '{4'b0001, -16'sd100, 1'b0}, 0, -1);
    watch(lat);
    chk("equal_lat", lat, 6);

    issue(6'd20, 8'd0, '{4'b0010, -16'sd1, 1'b0}, 0, -1);
    watch(lat);
    chk("neg_lat", lat, 6);

    // Explore: greedy would be right, random index 2 gives left.
    issue(6'd10, 8'd255, '{4'b0100, 16'sd30, 1'b1}, 0, 2);
    watch(lat);
    chk("explore_lat", lat, 6);

    av0 = av_count;
    issue(6'd7, 8'd0, '{4'b0010, 16'sd12, 1'b0}, 0, -1);
    fork
      watch(lat);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        start = 1'b1; cur = 6'd3;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("repeat_start_lat", lat, 6);
    chk("repeat_start_count", av_count - av0, 1);

    av0 = av_count;
    issue(6'd7, 8'd0, '{4'b0010, 16'sd12, 1'b0}, 0, -1);
    fork
      watch(lat);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; cur = 6'd3;
        @(posedge clk); @(posedge clk); #1 start = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("decide_start_lat", lat, 6);
    chk("decide_start_count", av_count - av0, 1);

    issue(6'd7, 8'd0, '{4'b0010, 16'sd12, 1'b0}, 0, -1);
    fork
      watch(lat);
      begin
        @(negedge clk); @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
      end
    join
    chk("en_stall_lat", lat, 9);

    issue(6'd63, 8'd0, '{4'b1000, 16'sd5, 1'b0}, 0, -1);
    watch(lat);
    check_reads(252);
    chk("wrap_lat", lat, 6);

    // Asynchronous reset in the middle of a read sequence.
    av0 = av_count;
    issue(6'd7, 8'd0, '{4'b0010, 16'sd12, 1'b0}, 0, -1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", q_rd_en, 0);
    chk("midrst_rd_addr", q_rd_addr, 0);
    chk("midrst_next_action", next_action, 1);
    chk("midrst_max_q", max_q, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_discard", av_count - av0, 0);

    issue(6'd7, 8'd0, '{4'b0010, 16'sd12, 1'b0}, 0, -1);
    watch(lat);
    chk("post_rst_lat", lat, 6);

    // Exploration rate at epsilon=64.
    st_n = 0; st_ex = 0;
    for (int k = 0; k < 4; k++) st_idx[k] = 0;
    stat_on = 1;
    for (int i = 0; i < 3000; i++) begin
      issue(6'($urandom_range(0, 63)), 8'd64, '0, 1, -1);
      watch(lat);
      chk("stat_lat", lat, 6);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("stat64_count", st_n, 3000);
    chk_range("explore_rate_eps64", st_ex, 690, 810);

    // Random action distribution at epsilon=255.
    st_n = 0; st_ex = 0;
    for (int k = 0; k < 4; k++) st_idx[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      issue(6'($urandom_range(0, 63)), 8'd255, '0, 1, -1);
      watch(lat);
      chk("stat_lat", lat, 6);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    stat_on = 0;
    chk_range("explore_rate_eps255", st_ex, 2950, 3000);
    for (int k = 0; k < 4; k++)
      chk_range("rnd_idx_share", st_idx[k], (st_ex * 23) / 100, (st_ex * 27) / 100);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
